exp_taylor_unit: RTL and testbench

//  Parametrised fixed-point e^x engine for the softmax datapath. Evaluates an N_TERMS Taylor series

---
 rtl/exp_taylor_unit.sv | 170 +++++++++++++++++
 tb/tb_exp_taylor_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/exp_taylor_unit.sv
// exp_taylor_unit: fixed-point e^x by an iterative Taylor series, one term per cycle.
// Optional build macro EXP_NEG_CLAMP_EN forces y=0 when x is below CLAMP_X at accept.
`default_nettype none

module exp_taylor_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4,
    parameter int N_TERMS    = 7,
    parameter int ACC_WIDTH  = DATA_WIDTH + 6,
    parameter int RECIP_BITS = 16,
    parameter int CLAMP_X    = -4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  ovf
);

    localparam int c_PW = ACC_WIDTH + DATA_WIDTH;
    localparam int c_RW = RECIP_BITS + 2;
    localparam int c_QW = c_PW + c_RW;
    localparam int c_CLAMP_LIM = CLAMP_X * (2 ** FRAC_BITS);
    localparam logic [3:0] c_KLAST = 4'(N_TERMS - 1);
    localparam logic signed [ACC_WIDTH-1:0] c_ONE = ACC_WIDTH'(1 << FRAC_BITS);
    localparam logic signed [ACC_WIDTH-1:0] c_AMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_AMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [c_QW-1:0] c_QMAX = {{(c_QW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [c_QW-1:0] c_QMIN = {{(c_QW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
`ifdef EXP_NEG_CLAMP_EN
    localparam bit c_CLAMP_EN = 1'b1;
`else
    localparam bit c_CLAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // round(2^RECIP_BITS / k) for k in 1..N_TERMS-1, zero elsewhere
    function automatic logic [RECIP_BITS:0] f_recip(input int k);
        longint num;
        if (k < 1 || k >= N_TERMS) return '0;
        num = (longint'(1) << RECIP_BITS) + longint'(k / 2);
        return (RECIP_BITS+1)'(num / longint'(k));
    endfunction

    state_t                        r_state, w_state_n;
    logic signed [DATA_WIDTH-1:0]  r_x;
    logic signed [ACC_WIDTH-1:0]   r_term, r_acc;
    logic [3:0]                    r_k;
    logic                          r_ovf_int, r_clamp;
    logic [DATA_WIDTH-1:0]         r_y;
    logic                          r_ovf;

    logic [RECIP_BITS:0]           w_recip [0:15];
    logic signed [c_PW-1:0]        w_term_ext, w_x_ext, w_prod1, w_p;
    logic signed [c_QW-1:0]        w_p_ext, w_recip_ext, w_prod2, w_tn_raw;
    logic                          w_tn_sat;
    logic signed [ACC_WIDTH-1:0]   w_tn, w_acc_n;
    logic signed [ACC_WIDTH:0]     w_sum;
    logic                          w_sum_sat, w_ovf_int_n;
    logic                          w_res_neg, w_res_big, w_clamp_hit;
    logic [DATA_WIDTH-1:0]         w_y_n;
    logic                          w_ovf_n;

    for (genvar gk = 0; gk < 16; gk++) begin : g_recip
        assign w_recip[gk] = f_recip(gk);
    end

    // term_n = ((term * x) >>> FRAC_BITS) * (1/k) >>> RECIP_BITS, full precision before saturation
    assign w_term_ext  = {{DATA_WIDTH{r_term[ACC_WIDTH-1]}}, r_term};
    assign w_x_ext     = {{ACC_WIDTH{r_x[DATA_WIDTH-1]}}, r_x};
    assign w_prod1     = w_term_ext * w_x_ext;
    assign w_p         = w_prod1 >>> FRAC_BITS;
    assign w_p_ext     = {{c_RW{w_p[c_PW-1]}}, w_p};
    assign w_recip_ext = {{(c_QW-RECIP_BITS-1){1'b0}}, w_recip[r_k]};
    assign w_prod2     = w_p_ext * w_recip_ext;
    assign w_tn_raw    = w_prod2 >>> RECIP_BITS;

    assign w_tn_sat = (w_tn_raw > c_QMAX) || (w_tn_raw < c_QMIN);
    assign w_tn     = w_tn_sat ? (w_tn_raw[c_QW-1] ? c_AMIN : c_AMAX)
                               : w_tn_raw[ACC_WIDTH-1:0];

    assign w_sum     = {r_acc[ACC_WIDTH-1], r_acc} + {w_tn[ACC_WIDTH-1], w_tn};
    assign w_sum_sat = w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1];
    assign w_acc_n   = w_sum_sat ? (w_sum[ACC_WIDTH] ? c_AMIN : c_AMAX)
                                 : w_sum[ACC_WIDTH-1:0];
    assign w_ovf_int_n = r_ovf_int | w_tn_sat | w_sum_sat;

    assign w_res_neg   = w_acc_n[ACC_WIDTH-1];
    assign w_res_big   = !w_res_neg && (|w_acc_n[ACC_WIDTH-2:DATA_WIDTH]);
    assign w_clamp_hit = c_CLAMP_EN && (int'($signed(x)) < c_CLAMP_LIM);

    always_comb begin
        w_y_n   = w_acc_n[DATA_WIDTH-1:0];
        w_ovf_n = w_ovf_int_n;
        if (r_clamp || w_res_neg) begin
            w_y_n   = '0;
            w_ovf_n = 1'b0;
        end else if (w_res_big) begin
            w_y_n   = '1;
            w_ovf_n = 1'b1;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)       w_state_n = S_CALC;
            S_CALC:  if (r_k == c_KLAST) w_state_n = S_DONE;
            S_DONE:  if (out_ready)      w_state_n = S_IDLE;
            default:                     w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_term    <= '0;
            r_acc     <= '0;
            r_k       <= '0;
            r_ovf_int <= 1'b0;
            r_clamp   <= 1'b0;
            r_y       <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_x       <= $signed(x);
                    r_term    <= c_ONE;
                    r_acc     <= c_ONE;
                    r_k       <= 4'd1;
                    r_ovf_int <= 1'b0;
                    r_clamp   <= w_clamp_hit;
                end
                S_CALC: begin
                    r_term    <= w_tn;
                    r_acc     <= w_acc_n;
                    r_k       <= r_k + 4'd1;
                    r_ovf_int <= w_ovf_int_n;
                    if (r_k == c_KLAST) begin
                        r_y   <= w_y_n;
                        r_ovf <= w_ovf_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign y         = r_y;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_exp_taylor_unit.sv
// tb_exp_taylor_unit: directed vectors with hand-computed results for exp_taylor_unit at defaults.
`default_nettype none

module tb_exp_taylor_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] r_yv;
    logic       r_ov;
    int         r_lat;

    exp_taylor_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts edges until out_valid, giving up after 20
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] xv, output logic [7:0] yv, output logic ov, output int lat);
        @(negedge clk);
        x        = xv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x        = 8'hAA;
        wait_out(lat);
        yv = y;
        ov = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'h00);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        run_op(8'h00, r_yv, r_ov, r_lat);
        check("x0_y", 32'(r_yv), 32'h10);
        check("x0_ovf", 32'(r_ov), 32'd0);
        check("x0_latency", 32'(r_lat), 32'd6);
        check("x0_pop_out_valid", 32'(out_valid), 32'd0);
        check("x0_pop_in_ready", 32'(in_ready), 32'd1);

        // Truncated terms 16+16+8+2 give 0x2A; allow up to the rounded e
        run_op(8'h10, r_yv, r_ov, r_lat);
        check("xp1_y_range", 32'(r_yv >= 8'h2A && r_yv <= 8'h2C), 32'd1);
        check("xp1_ovf", 32'(r_ov), 32'd0);

        run_op(8'hF0, r_yv, r_ov, r_lat);
        check("xm1_y_range", 32'(r_yv >= 8'h05 && r_yv <= 8'h06), 32'd1);
        check("xm1_ovf", 32'(r_ov), 32'd0);

        run_op(8'h30, r_yv, r_ov, r_lat);
        check("xp3_y", 32'(r_yv), 32'hFF);
        check("xp3_ovf", 32'(r_ov), 32'd1);

        run_op(8'h80, r_yv, r_ov, r_lat);
`ifdef EXP_NEG_CLAMP_EN
        check("xm8_y", 32'(r_yv), 32'h00);
        check("xm8_ovf", 32'(r_ov), 32'd0);
`else
        check("xm8_y", 32'(r_yv), 32'hFF);
        check("xm8_ovf", 32'(r_ov), 32'd1);
`endif
        check("xm8_latency", 32'(r_lat), 32'd6);

        // Backpressure: result held, extra in_valid pulses ignored
        @(negedge clk);
        x = 8'h00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(r_lat);
        check("bp_latency", 32'(r_lat), 32'd6);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            x        = 8'h30;
            @(posedge clk); #1;
            check("bp_hold_y", 32'(y), 32'h10);
            check("bp_hold_ovf", 32'(ovf), 32'd0);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_out_valid", 32'(out_valid), 32'd1);
        end
        // Pop with a new request already present: accepted one cycle later
        in_valid = 1'b1; x = 8'h00; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_pop_out_valid", 32'(out_valid), 32'd0);
        check("bp_pop_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accept", 32'(in_ready), 32'd0);
        wait_out(r_lat);
        check("bp_next_latency", 32'(r_lat), 32'd6);
        check("bp_next_y", 32'(y), 32'h10);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_next_pop", 32'(in_ready), 32'd1);

        // Reset three cycles into a calculation aborts it
        @(negedge clk);
        x = 8'h30; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_result", 32'(out_valid), 32'd0);
        run_op(8'h00, r_yv, r_ov, r_lat);
        check("after_abort_y", 32'(r_yv), 32'h10);
        check("after_abort_ovf", 32'(r_ov), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

`default_nettype wire
